sprite_line_renderer: RTL and testbench

Consumer stage for the synchronous sprite ROM. Each ROM word is one WIDTH-bit, 1-bpp sprite row.
- Once per scanline, fetches the sprite row for the coming line and absorbs the ROM's 1-cycle read latency.
- Latches the row into a line buffer, then shifts it out pixel-by-pixel as the beam crosses the sprite's x position.
- Sits between the VGA timing generator and the colour mux; output pix marks opaque sprite pixels.

---
 rtl/sprite_line_renderer_pkg.sv | 16 +
 rtl/sprite_shifter.sv | 58 +++++
 rtl/sprite_line_renderer.sv | 124 ++++++++++++
 tb/tb_sprite_line_renderer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sprite_line_renderer_pkg.sv
// Shared types for the sprite pipeline stages (state encoding, coordinate width default).
// Latency: none, types and constants only.
// Backpressure: none.
package sprite_line_renderer_pkg;

  localparam int CORDW_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    READY,
    DRAW
  } spr_state_e;

endpackage

// File: rtl/sprite_shifter.sv
// Line buffer for one sprite row plus scale/pixel counters; MSB is the current pixel.
// Latency: load/start/adv take effect on the next clk edge; msb/done are combinational from state.
// Backpressure: none, the controller advances it once per pixel clock while drawing.
// Ports: load/load_dat capture a row, start rewinds the counters, adv steps one cycle,
//        msb is the pixel under the beam, done marks the last cycle of the scaled span.
module sprite_shifter #(
  parameter int WIDTH = 30,
  parameter int SCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             start,
  input  logic             adv,
  output logic             msb,
  output logic             done
);

  localparam int SCW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int PCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] line_buf;
  logic [SCW-1:0]   sc;
  logic [PCW-1:0]   pc;
  logic             sc_wrap;

  assign sc_wrap = (sc == SCW'(SCALE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_buf <= '0;
      sc       <= '0;
      pc       <= '0;
    end else begin
      if (load) begin
        line_buf <= load_dat;
      end
      if (start) begin
        sc <= '0;
        pc <= '0;
      end else if (adv) begin
        // Each source pixel is held for SCALE cycles before the next one moves up.
        if (sc_wrap) begin
          sc       <= '0;
          pc       <= pc + PCW'(1);
          line_buf <= line_buf << 1;
        end else begin
          sc <= sc + SCW'(1);
        end
      end
    end
  end

  assign msb  = line_buf[WIDTH-1];
  assign done = sc_wrap && (pc == PCW'(WIDTH - 1));

endmodule

// File: rtl/sprite_line_renderer.sv
// Per-scanline sprite row fetch from a 1-cycle ROM, then pixel-serial emission across the sprite span.
// Latency: row fetched 2 cycles after line_start; pix lags the matching sx by 1 cycle.
// Backpressure: none; a ROM address echo mismatch re-issues the fetch, line_start aborts anything in flight.
// Ports: line_start/sy/spr_x/spr_y set up the next line, sx/de track the beam,
//        rom_addr/rom_addr_ret/rom_data talk to the sprite ROM, pix/drawing feed the colour mux.
module sprite_line_renderer
  import sprite_line_renderer_pkg::*;
#(
  parameter  int WIDTH = 30,
  parameter  int DEPTH = 21,
  parameter  int CORDW = CORDW_DEF,
  parameter  int SCALE = 1,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line_start,
  input  logic [CORDW-1:0] sy,
  input  logic [CORDW-1:0] sx,
  input  logic             de,
  input  logic [CORDW-1:0] spr_x,
  input  logic [CORDW-1:0] spr_y,
  output logic [ADDRW-1:0] rom_addr,
  input  logic [ADDRW-1:0] rom_addr_ret,
  input  logic [WIDTH-1:0] rom_data,
  output logic             pix,
  output logic             drawing
);

  if (!(SCALE == 1 || SCALE == 2 || SCALE == 4 || SCALE == 8)) begin : g_bad_scale
    $error("sprite_line_renderer: SCALE must be 1, 2, 4 or 8");
  end

  localparam int SPAN_H = DEPTH * SCALE;
  localparam int SSH    = $clog2(SCALE);

  spr_state_e       state, state_n;
  logic [CORDW-1:0] x_lat;
  logic [ADDRW-1:0] row_lat;
  logic [CORDW:0]   dy;
  logic             in_range;
  logic [ADDRW-1:0] new_row;
  logic             sh_load, sh_start, sh_adv, sh_msb, sh_done;

  // One extra bit keeps the sign so lines above the sprite read as negative.
  assign dy       = {1'b0, sy} - {1'b0, spr_y};
  assign in_range = !dy[CORDW] && (dy < (CORDW + 1)'(SPAN_H));
  assign new_row  = ADDRW'(dy >> SSH);

  always_comb begin
    state_n  = state;
    sh_load  = 1'b0;
    sh_start = 1'b0;
    sh_adv   = 1'b0;
    if (line_start) begin
      state_n = in_range ? FETCH : IDLE;
    end else begin
      case (state)
        FETCH: state_n = WAIT;
        WAIT: begin
          if (rom_addr_ret == row_lat) begin
            sh_load = 1'b1;
            state_n = READY;
          end else begin
            state_n = FETCH;
          end
        end
        READY: begin
          if (de && sx == x_lat) begin
            sh_start = 1'b1;
            state_n  = DRAW;
          end
        end
        DRAW: begin
          // Falling de clips a sprite hanging off the right edge.
          if (!de || sh_done) begin
            state_n = IDLE;
          end else begin
            sh_adv = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      x_lat    <= '0;
      row_lat  <= '0;
      rom_addr <= '0;
    end else begin
      state <= state_n;
      if (line_start) begin
        x_lat <= spr_x;
        if (in_range) begin
          row_lat  <= new_row;
          rom_addr <= new_row;
        end
      end else if (state_n == FETCH) begin
        rom_addr <= row_lat;
      end
    end
  end

  sprite_shifter #(
    .WIDTH (WIDTH),
    .SCALE (SCALE)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sh_load),
    .load_dat (rom_data),
    .start    (sh_start),
    .adv      (sh_adv),
    .msb      (sh_msb),
    .done     (sh_done)
  );

  assign drawing = (state == DRAW);
  assign pix     = drawing && sh_msb;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Bench for sprite_line_renderer: SCALE=1 and SCALE=2 instances share the beam, each with its own ROM.
// Latency: expectations follow the 2-cycle fetch and 1-cycle pix lag.
// Backpressure: n/a.
module tb_sprite_line_renderer;

  localparam int W  = 30;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          line_start;
  logic [9:0]    sy, sx, spr_x, spr_y;
  logic          de;
  logic          glitch;
  logic [AW-1:0] a1, a2, rr1, rr2;
  logic [W-1:0]  rd1, rd2;
  logic          pix1, pix2, drw1, drw2;

  logic [W-1:0]  rom [0:31];

  int checks   = 0;
  int failures = 0;

  // Reference model state per instance (0: SCALE=1, 1: SCALE=2).
  bit m_lv [2];
  bit m_used [2];
  int m_x [2];
  int m_age [2];
  int m_ready [2];
  int m_hit [2];
  int m_row [2];
  int m_addr [2];

  sprite_line_renderer #(.SCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .sy(sy), .sx(sx), .de(de),
    .spr_x(spr_x), .spr_y(spr_y), .rom_addr(a1), .rom_addr_ret(rr1), .rom_data(rd1),
    .pix(pix1), .drawing(drw1)
  );

  sprite_line_renderer #(.SCALE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .sy(sy), .sx(sx), .de(de),
    .spr_x(spr_x), .spr_y(spr_y), .rom_addr(a2), .rom_addr_ret(rr2), .rom_data(rd2),
    .pix(pix2), .drawing(drw2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs; glitch corrupts both the echoed address and the data of the first instance.
  always @(posedge clk) begin
    rd1 <= glitch ? ~rom[a1] : rom[a1];
    rr1 <= glitch ? ~a1 : a1;
    rd2 <= rom[a2];
    rr2 <= a2;
  end

  task automatic model_step(input bit rst, input bit ls, input bit gl);
    for (int k = 0; k < 2; k++) begin
      int s;
      int dy;
      s = (k == 0) ? 1 : 2;
      if (!rst) begin
        m_lv[k] = 0; m_hit[k] = -1; m_addr[k] = 0; m_used[k] = 1;
      end else if (ls) begin
        dy = int'(sy) - int'(spr_y);
        m_lv[k]    = (dy >= 0 && dy < 21 * s);
        m_x[k]     = int'(spr_x);
        m_age[k]   = 0;
        m_hit[k]   = -1;
        m_used[k]  = 0;
        m_ready[k] = (k == 0 && gl) ? 5 : 3;
        if (m_lv[k]) begin
          m_row[k]  = dy / s;
          m_addr[k] = dy / s;
        end
      end else begin
        m_age[k]++;
        if (m_hit[k] >= 0) begin
          if (!de || m_hit[k] == W * s - 1) m_hit[k] = -1;
          else m_hit[k]++;
        end else if (m_lv[k] && !m_used[k] && m_age[k] >= m_ready[k] && de && int'(sx) == m_x[k]) begin
          m_hit[k]  = 0;
          m_used[k] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input int line, input int i);
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] w;
      logic         ep;
      int           s;
      s  = (k == 0) ? 1 : 2;
      w  = rom[m_row[k]];
      ep = (m_hit[k] >= 0) ? w[W - 1 - m_hit[k] / s] : 1'b0;
      if (k == 0) begin
        chk($sformatf("pix_s1 line%0d sx%0d", line, i), {31'd0, pix1}, {31'd0, ep});
        chk($sformatf("drawing_s1 line%0d sx%0d", line, i), {31'd0, drw1}, {31'd0, m_hit[k] >= 0});
        chk($sformatf("rom_addr_s1 line%0d sx%0d", line, i), {27'd0, a1}, m_addr[k]);
      end else begin
        chk($sformatf("pix_s2 line%0d sx%0d", line, i), {31'd0, pix2}, {31'd0, ep});
        chk($sformatf("drawing_s2 line%0d sx%0d", line, i), {31'd0, drw2}, {31'd0, m_hit[k] >= 0});
        chk($sformatf("rom_addr_s2 line%0d sx%0d", line, i), {27'd0, a2}, m_addr[k]);
      end
    end
  endtask

  // One 800-clock line: active 0..639, next-line setup at sx=700.
  task automatic sweep(input int line, input int nsy, input int nx, input int ny, input bit gl_req,
                       input int abort_at, input int a_sy, input int a_x, input int a_y, input int rst_at);
    for (int i = 0; i < 800; i++) begin
      sx         = 10'(i);
      de         = (i < 640);
      line_start = 1'b0;
      glitch     = gl_req && (i == 701);
      rst_n      = !(rst_at >= 0 && i >= rst_at && i < rst_at + 3);
      // Setup inputs carry junk except on line_start, so latching is exercised.
      sy    = 10'($urandom_range(0, 1023));
      spr_x = 10'($urandom_range(0, 1023));
      spr_y = 10'($urandom_range(0, 1023));
      if (i == 700) begin
        line_start = 1'b1; sy = 10'(nsy); spr_x = 10'(nx); spr_y = 10'(ny);
      end
      if (i == abort_at) begin
        line_start = 1'b1; sy = 10'(a_sy); spr_x = 10'(a_x); spr_y = 10'(a_y);
      end
      model_step(rst_n, line_start, gl_req && i == 700);
      @(negedge clk);
      check_outputs(line, i);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = W'($urandom);
    rom[3] = 30'h2000_0001;
    rst_n = 1'b0; line_start = 1'b0; de = 1'b0; glitch = 1'b0;
    sx = '0; sy = '0; spr_x = '0; spr_y = '0;
    for (int k = 0; k < 2; k++) begin
      m_hit[k] = -1; m_row[k] = 0; m_addr[k] = 0; m_lv[k] = 0; m_used[k] = 1;
      m_age[k] = 0; m_ready[k] = 3; m_x[k] = 0;
    end
    for (int c = 0; c < 3; c++) begin
      model_step(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_outputs(-1, c);
    end

    sweep(0, 103, 200, 100, 0, -1, 0, 0, 0, -1);   // prime: row 3 at x=200
    sweep(1,  99, 200, 100, 0, -1, 0, 0, 0, -1);   // draws row 3; next line above sprite
    sweep(2, 121, 200, 100, 0, -1, 0, 0, 0, -1);   // nothing; next is past SCALE=1 bottom
    sweep(3, 120, 200, 100, 0, -1, 0, 0, 0, -1);   // SCALE=2 only; next is last row
    sweep(4, 105, 200, 100, 0, -1, 0, 0, 0, -1);   // row 20; next row 5 / row 2
    sweep(5, 102, 630, 100, 0, -1, 0, 0, 0, -1);   // next clips at the right edge
    sweep(6, 110, 100, 100, 0, -1, 0, 0, 0, -1);   // clip line
    sweep(7, 104,  50, 100, 1, 115, 111, 400, 100, -1);  // abort mid-span, next fetch glitched
    sweep(8, 103, 300, 100, 0, -1, 0, 0, 0, -1);   // retried fetch line
    sweep(9, 108, 20, 100, 0, -1, 0, 0, 0, 310);   // reset mid-span
    for (int l = 10; l < 16; l++) begin
      sweep(l, int'($urandom_range(90, 150)), int'($urandom_range(0, 1023)),
            int'($urandom_range(95, 110)), 0, -1, 0, 0, 0, -1);
    end
    sweep(16, 0, 0, 500, 0, -1, 0, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
